calc_controller: RTL and testbench
==================================

Name: calc_controller

Overview:
- Top-level sequencer for the calculator datapath.
- Walks a memory range of 64-bit words; each word feeds the adder as {upper 32, lower 32}.
- Steers each 32-bit sum into the lower or upper half of the result buffer (loc_sel), then writes the filled 64-bit buffer back to memory.
- Sits between a host start/config interface and the memory, adder and result-buffer datapath.

Parameters:
- DATA_W, 32, adder result width / half-buffer width
- MEM_WORD_SIZE, 64, memory word and result-buffer width (= 2*DATA_W)
- ADDR_W, 10, memory address width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start request, sampled in IDLE only
- rd_start_addr_i  in  ADDR_W  first operand word address
- rd_end_addr_i  in  ADDR_W  last operand word address (inclusive)
- wr_start_addr_i  in  ADDR_W  first result word address
- mem_rd_en_o  out  1  memory read strobe; data valid one cycle later
- mem_rd_addr_o  out  ADDR_W  read address
- mem_wr_en_o  out  1  memory write strobe; memory samples buffer_o at the same edge
- mem_wr_addr_o  out  ADDR_W  write address
- loc_sel_o  out  1  result-buffer half select (0 = lower, 1 = upper)
- buf_clr_o  out  1  synchronous clear of the result buffer
- pad_o  out  1  forces the datapath's buffer input to 0
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset: async on rst_ni low.
  - State = IDLE; all outputs 0; internal address and half registers 0.
  - Reset mid-operation aborts immediately; no write in progress completes.
- All outputs are registered/Moore (decoded from state and regs); no combinational path from inputs to outputs.
- States: IDLE, CLR, READ, WAIT, ADD, PAD, WRITE, DONE.
- IDLE:
  - start_i=1 and rd_start<=rd_end: latch all three addresses, go to CLR.
  - start_i=1 and rd_start>rd_end: err_o=1 next cycle, stay IDLE.
- CLR: buf_clr_o=1 for one cycle; half<=0; go to READ.
- READ: mem_rd_en_o=1, mem_rd_addr_o=cur_rd; go to WAIT.
- WAIT: read data settling; go to ADD.
- ADD: operands valid, and the buffer captures the sum into half loc_sel at this cycle's closing edge.
  - half=0, cur_rd!=end: half<=1, cur_rd++, go to READ.
  - half=0, cur_rd==end: half<=1, go to PAD (odd word count).
  - half=1: half<=0, go to WRITE.
- PAD: pad_o=1, loc_sel_o=1, so the upper half captures 0; half<=0; go to WRITE.
- WRITE: mem_wr_en_o=1, mem_wr_addr_o=cur_wr; cur_wr++.
  - More words remain (cur_rd!=end): cur_rd++, go to READ.
  - Otherwise go to DONE.
- DONE: done_o=1; go to IDLE.
- loc_sel_o = half register at all times.
  - The buffer writes every cycle, so only the ADD/PAD edges matter.
  - The non-selected half is never disturbed.
- start_i while busy_o=1 is ignored; no queuing.
- Address arithmetic wraps modulo 2^ADDR_W. rd_end = 2^ADDR_W-1 is legal; the end test uses equality, never overflow.
- Latency for N operand words:
  - even N: 2 + 3N + N/2 cycles from accept to done_o (e.g. N=2 gives 9);
  - odd N: one extra PAD cycle.
- Writes issued = ceil(N/2), at consecutive addresses from wr_start.

Test Plan:
- Two words: mem[0]={5,3}, mem[1]={20,10}, range 0..1, wr 0x100, start pulse -> write at 0x100 = 0x0000001E_00000008; done_o 9 cycles after start; busy_o high throughout.
- Odd count: range 4..6 with sums 1,2,3, wr 0x10 -> mem[0x10]=0x00000002_00000001, mem[0x11]=0x00000000_00000003; exactly one PAD cycle with pad_o=1.
- Bad range: rd_start=7, rd_end=3 -> err_o one-cycle pulse; no mem strobes; busy_o stays 0.
- Start while busy: second start_i pulse mid-run with different addresses -> ignored; results only at the first wr_start.
- Async reset: assert rst_ni=0 between first ADD and WRITE -> outputs 0 immediately without a clock edge; no write; a new start after release runs cleanly.
- Wrap: range 0x3FE..0x3FF, wr 0x3FF -> one write at 0x3FF; cur_wr wraps to 0; done_o asserted.

Source files
------------

// File: rtl/calc_controller.sv
// Sequencer for the calculator datapath: walks an operand range of 64-bit words,
// pairs the 32-bit sums into the result buffer and writes each full buffer back.
module calc_controller #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MEM_WORD_SIZE = 64,
    parameter int unsigned ADDR_W        = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] rd_start_addr_i,
    input  logic [ADDR_W-1:0] rd_end_addr_i,
    input  logic [ADDR_W-1:0] wr_start_addr_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic              loc_sel_o,
    output logic              buf_clr_o,
    output logic              pad_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] S_CLR   = 3'd1;
    localparam logic [ST_W-1:0] S_READ  = 3'd2;
    localparam logic [ST_W-1:0] S_WAIT  = 3'd3;
    localparam logic [ST_W-1:0] S_ADD   = 3'd4;
    localparam logic [ST_W-1:0] S_PAD   = 3'd5;
    localparam logic [ST_W-1:0] S_WRITE = 3'd6;
    localparam logic [ST_W-1:0] S_DONE  = 3'd7;

    // The result buffer must hold exactly two adder results.
    generate
        if (MEM_WORD_SIZE != 2 * DATA_W) begin : g_bad_width
            $error("calc_controller: MEM_WORD_SIZE must equal 2*DATA_W");
        end
    endgenerate

    logic [ST_W-1:0]   state_q,  state_d;
    logic [ADDR_W-1:0] cur_rd_q, cur_rd_d;
    logic [ADDR_W-1:0] rd_end_q, rd_end_d;
    logic [ADDR_W-1:0] cur_wr_q, cur_wr_d;
    logic              half_q,   half_d;
    logic              rd_en_q,  rd_en_d;
    logic              wr_en_q,  wr_en_d;
    logic              clr_q,    clr_d;
    logic              pad_q,    pad_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              err_q,    err_d;

    // Next-state and address/half bookkeeping.
    always_comb begin
        state_d  = state_q;
        cur_rd_d = cur_rd_q;
        rd_end_d = rd_end_q;
        cur_wr_d = cur_wr_q;
        half_d   = half_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (rd_start_addr_i <= rd_end_addr_i) begin
                        cur_rd_d = rd_start_addr_i;
                        rd_end_d = rd_end_addr_i;
                        cur_wr_d = wr_start_addr_i;
                        state_d  = S_CLR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLR: begin
                half_d  = 1'b0;
                state_d = S_READ;
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: state_d = S_ADD;
            S_ADD: begin
                if (!half_q) begin
                    half_d = 1'b1;
                    if (cur_rd_q != rd_end_q) begin
                        cur_rd_d = cur_rd_q + ADDR_W'(1);
                        state_d  = S_READ;
                    end else begin
                        state_d = S_PAD;
                    end
                end else begin
                    half_d  = 1'b0;
                    state_d = S_WRITE;
                end
            end
            S_PAD: begin
                half_d  = 1'b0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                cur_wr_d = cur_wr_q + ADDR_W'(1);
                if (cur_rd_q != rd_end_q) begin
                    cur_rd_d = cur_rd_q + ADDR_W'(1);
                    state_d  = S_READ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the flops track the state register.
    always_comb begin
        rd_en_d = (state_d == S_READ);
        wr_en_d = (state_d == S_WRITE);
        clr_d   = (state_d == S_CLR);
        pad_d   = (state_d == S_PAD);
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cur_rd_q <= '0;
            rd_end_q <= '0;
            cur_wr_q <= '0;
            half_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            clr_q    <= 1'b0;
            pad_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_rd_q <= cur_rd_d;
            rd_end_q <= rd_end_d;
            cur_wr_q <= cur_wr_d;
            half_q   <= half_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            clr_q    <= clr_d;
            pad_q    <= pad_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign mem_rd_en_o   = rd_en_q;
    assign mem_rd_addr_o = cur_rd_q;
    assign mem_wr_en_o   = wr_en_q;
    assign mem_wr_addr_o = cur_wr_q;
    assign loc_sel_o     = half_q;
    assign buf_clr_o     = clr_q;
    assign pad_o         = pad_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_calc_controller.sv
// Bench for calc_controller: memory, adder and result buffer around the DUT,
// with expected writes derived from the operand words by pairing their sums.
module tb_calc_controller;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [9:0] rd_start_addr_i = '0;
    logic [9:0] rd_end_addr_i = '0;
    logic [9:0] wr_start_addr_i = '0;
    logic       mem_rd_en_o;
    logic [9:0] mem_rd_addr_o;
    logic       mem_wr_en_o;
    logic [9:0] mem_wr_addr_o;
    logic       loc_sel_o;
    logic       buf_clr_o;
    logic       pad_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    calc_controller dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .rd_start_addr_i (rd_start_addr_i),
        .rd_end_addr_i   (rd_end_addr_i),
        .wr_start_addr_i (wr_start_addr_i),
        .mem_rd_en_o     (mem_rd_en_o),
        .mem_rd_addr_o   (mem_rd_addr_o),
        .mem_wr_en_o     (mem_wr_en_o),
        .mem_wr_addr_o   (mem_wr_addr_o),
        .loc_sel_o       (loc_sel_o),
        .buf_clr_o       (buf_clr_o),
        .pad_o           (pad_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] mem [1024];
    logic [63:0] rd_data;
    logic [63:0] buffer;
    logic [31:0] dp_sum;
    logic [9:0]  wlog_a [$];
    logic [63:0] wlog_d [$];
    int          rd_cnt = 0;
    int          pad_cnt = 0;

    assign dp_sum = rd_data[63:32] + rd_data[31:0];

    // Datapath: registered read port, half-steered result buffer, write logger.
    always @(posedge clk_i) begin
        if (mem_rd_en_o) rd_data <= mem[mem_rd_addr_o];
        if (buf_clr_o) buffer <= '0;
        else if (loc_sel_o) buffer[63:32] <= pad_o ? 32'd0 : dp_sum;
        else buffer[31:0] <= pad_o ? 32'd0 : dp_sum;
        if (mem_wr_en_o) begin
            wlog_a.push_back(mem_wr_addr_o);
            wlog_d.push_back(buffer);
        end
    end

    always @(negedge clk_i) begin
        if (mem_rd_en_o) rd_cnt++;
        if (pad_o) pad_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_sum(input logic [63:0] w);
        return w[63:32] + w[31:0];
    endfunction

    function automatic logic [63:0] last_write(input logic [9:0] a);
        for (int i = wlog_a.size() - 1; i >= 0; i--)
            if (wlog_a[i] == a) return wlog_d[i];
        return 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    function automatic logic [63:0] all_outputs();
        return 64'({mem_rd_en_o, mem_wr_en_o, loc_sel_o, buf_clr_o, pad_o,
                    busy_o, done_o, err_o, mem_rd_addr_o, mem_wr_addr_o});
    endfunction

    // One full operation: builds the expected write list, runs, and compares.
    task automatic run_op(input logic [9:0] rs, input logic [9:0] re,
                          input logic [9:0] ws, input bit intrude);
        int          n;
        int          exp_lat;
        int          cyc;
        int          rd0;
        int          pad0;
        int          w0;
        bit          busy_ok;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [63:0] exp_d [$];
        logic [9:0]  exp_a [$];

        n = int'(re - rs) + 1;
        for (int k = 0; k < n; k += 2) begin
            lo = word_sum(mem[rs + 10'(k)]);
            hi = (k + 1 < n) ? word_sum(mem[rs + 10'(k + 1)]) : 32'd0;
            exp_d.push_back({hi, lo});
            exp_a.push_back(ws + 10'(k / 2));
        end
        exp_lat = 2 + 3 * n + (n + 1) / 2 + (n % 2);

        rd0  = rd_cnt;
        pad0 = pad_cnt;
        w0   = wlog_a.size();

        @(negedge clk_i);
        rd_start_addr_i = rs;
        rd_end_addr_i   = re;
        wr_start_addr_i = ws;
        start_i         = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!done_o && cyc < 200) begin
            if (!busy_o) busy_ok = 1'b0;
            if (intrude && cyc == 3) begin
                start_i         = 1'b1;
                rd_start_addr_i = 10'h020;
                rd_end_addr_i   = 10'h021;
                wr_start_addr_i = 10'h200;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;
        if (!busy_o) busy_ok = 1'b0;

        check_eq("latency", 64'(cyc), 64'(exp_lat));
        check_eq("busy_during_run", 64'(busy_ok), 64'd1);
        @(negedge clk_i);
        #1;
        check_eq("busy_after_done", 64'(busy_o), 64'd0);
        check_eq("done_pulse_width", 64'(done_o), 64'd0);
        check_eq("read_count", 64'(rd_cnt - rd0), 64'(n));
        check_eq("pad_count", 64'(pad_cnt - pad0), 64'(n % 2));
        check_eq("write_count", 64'(wlog_a.size() - w0), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && w0 + i < wlog_a.size(); i++) begin
            check_eq("write_addr", 64'(wlog_a[w0 + i]), 64'(exp_a[i]));
            check_eq("write_data", wlog_d[w0 + i], exp_d[i]);
        end
    endtask

    initial begin
        int          rd0;
        int          w0;
        int          n;
        logic [9:0]  rs;
        logic [9:0]  ws;

        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};

        #1;
        check_eq("reset_outputs", all_outputs(), 64'd0);
        #12;
        rst_ni = 1'b1;

        // Two words, even count.
        mem[0] = {32'd5, 32'd3};
        mem[1] = {32'd20, 32'd10};
        run_op(10'h000, 10'h001, 10'h100, 1'b0);
        check_eq("two_word_result", last_write(10'h100), 64'h0000001E_00000008);

        // Odd count, upper half of the last buffer padded.
        mem[4] = {32'd0, 32'd1};
        mem[5] = {32'd1, 32'd1};
        mem[6] = {32'd2, 32'd1};
        run_op(10'h004, 10'h006, 10'h010, 1'b0);
        check_eq("odd_result_0", last_write(10'h010), 64'h00000002_00000001);
        check_eq("odd_result_1", last_write(10'h011), 64'h00000000_00000003);

        // Inverted range is rejected.
        rd0 = rd_cnt;
        w0  = wlog_a.size();
        @(negedge clk_i);
        rd_start_addr_i = 10'd7;
        rd_end_addr_i   = 10'd3;
        wr_start_addr_i = 10'h050;
        start_i         = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check_eq("err_pulse", 64'(err_o), 64'd1);
        check_eq("err_busy", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        check_eq("err_pulse_width", 64'(err_o), 64'd0);
        repeat (3) @(negedge clk_i);
        #1;
        check_eq("err_no_reads", 64'(rd_cnt - rd0), 64'd0);
        check_eq("err_no_writes", 64'(wlog_a.size() - w0), 64'd0);
        check_eq("err_busy_later", 64'(busy_o), 64'd0);

        // Start while busy is ignored.
        run_op(10'h030, 10'h035, 10'h120, 1'b1);
        check_eq("intrude_no_write", last_write(10'h200), 64'hDEAD_BEEF_DEAD_BEEF);

        // Asynchronous reset mid-operation.
        w0 = wlog_a.size();
        @(negedge clk_i);
        rd_start_addr_i = 10'h040;
        rd_end_addr_i   = 10'h041;
        wr_start_addr_i = 10'h300;
        start_i         = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check_eq("pre_reset_loc_sel", 64'(loc_sel_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("async_reset_outputs", all_outputs(), 64'd0);
        repeat (3) @(negedge clk_i);
        check_eq("reset_no_write", 64'(wlog_a.size() - w0), 64'd0);
        #2;
        rst_ni = 1'b1;
        run_op(10'h040, 10'h041, 10'h300, 1'b0);

        // Range ending at the top address, write address wraps afterwards.
        run_op(10'h3FE, 10'h3FF, 10'h3FF, 1'b0);
        check_eq("wrap_wr_addr", 64'(mem_wr_addr_o), 64'd0);

        // Randomized ranges and data.
        for (int r = 0; r < 10; r++) begin
            n  = (r % 2 == 1) ? int'($urandom_range(2, 8)) : int'($urandom_range(1, 8));
            rs = 10'($urandom_range(64, 500));
            ws = 10'($urandom_range(512, 1000));
            for (int k = 0; k < n; k++) mem[rs + 10'(k)] = {$urandom, $urandom};
            run_op(rs, rs + 10'(n - 1), ws, r % 2 == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
